prog_clock_divider: RTL and testbench

//  Parametrised, runtime-programmable successor to the fixed clock divider.

---
 rtl/prog_clock_divider.sv | 187 ++++++++++++++++++
 tb/tb_prog_clock_divider.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: runtime-programmable integer clock divider (N = 2..2^WIDTH-1).
// New divisors arrive over a valid/ready handshake and are applied only at
// period boundaries (or while idle), so clk_out never produces a short pulse.
// Optional feature macro: CLKDIV_HALF_DUTY_EN. When defined, odd divisors give
// an exact 50% duty cycle by OR-ing in a negedge-delayed copy of the phase.
// When undefined, only posedge logic is used and odd N is ceil/floor duty.
module prog_clock_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TWO     = WIDTH'(2);

  // Divisors below 2 cannot form a period with both phases, so they map to 2.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    if (d < C_TWO) begin
      clamp_div = C_TWO;
    end else begin
      clamp_div = d;
    end
  endfunction

  // Number of posedge-phase high cycles for divisor d (one extra bit avoids overflow).
  function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] d);
`ifdef CLKDIV_HALF_DUTY_EN
    high_len = {1'b0, d} >> 1;
`else
    high_len = ({1'b0, d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
`endif
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend_valid;
  logic             r_pos;
  logic             r_tick;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_pend_div_nxt;
  logic             w_pend_valid_nxt;
  logic             w_pos_nxt;
  logic             w_tick_nxt;
  logic             w_active;
  logic             w_wrap;
  logic             w_accept;
  logic             w_apply;
  logic             w_run_nxt;

  // Next-state, counter, divisor handshake and output-phase decode.
  always_comb begin
    w_state_nxt      = ST_IDLE;
    w_cnt_nxt        = '0;
    w_div_nxt        = r_cur_div;
    w_pend_div_nxt   = r_pend_div;
    w_pend_valid_nxt = r_pend_valid;
    w_pos_nxt        = 1'b0;
    w_tick_nxt       = 1'b0;

    w_active = (r_state != ST_IDLE);
    w_wrap   = w_active && (r_cnt == (r_cur_div - C_ONE));
    w_accept = div_valid && !r_pend_valid;
    w_apply  = r_pend_valid && (!w_active || w_wrap);

    // en sampled low on the wrap edge ends the run right at the period boundary.
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (en) begin
          w_state_nxt = ST_RUN;
        end else if (w_wrap) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_active && !w_wrap) begin
      w_cnt_nxt = r_cnt + C_ONE;
    end else begin
      w_cnt_nxt = '0;
    end

    if (w_apply) begin
      w_div_nxt        = r_pend_div;
      w_pend_valid_nxt = 1'b0;
    end else if (w_accept) begin
      w_pend_valid_nxt = 1'b1;
    end else begin
      w_pend_valid_nxt = r_pend_valid;
    end

    if (w_accept) begin
      w_pend_div_nxt = clamp_div(div_in);
    end else begin
      w_pend_div_nxt = r_pend_div;
    end

    w_run_nxt  = (w_state_nxt != ST_IDLE);
    w_pos_nxt  = w_run_nxt && ({1'b0, w_cnt_nxt} < high_len(w_div_nxt));
    w_tick_nxt = w_run_nxt && (w_cnt_nxt == (w_div_nxt - C_ONE));
  end

  // State, counter, divisor and registered phase/tick outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cur_div    <= C_DEF_DIV;
      r_pend_div   <= C_DEF_DIV;
      r_pend_valid <= 1'b0;
      r_pos        <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cur_div    <= w_div_nxt;
      r_pend_div   <= w_pend_div_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pos        <= w_pos_nxt;
      r_tick       <= w_tick_nxt;
    end
  end

`ifdef CLKDIV_HALF_DUTY_EN
  logic r_odd;
  logic r_neg;

  // Remember whether the period being emitted uses an odd divisor.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_odd <= 1'b0;
    end else begin
      r_odd <= w_run_nxt && w_div_nxt[0];
    end
  end

  // Half-cycle delayed copy of the phase; stretches odd-N high time by 0.5 cycle.
  always_ff @(negedge clk_in or negedge reset) begin
    if (!reset) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  assign clk_out = r_pos | (r_odd & r_neg);
`else
  assign clk_out = r_pos;
`endif

  assign tick      = r_tick;
  assign div_ready = !r_pend_valid;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider (default build, odd N = ceil/floor duty).
// A period-level reference model pushes expected outputs into a queue on every
// clock edge; an independent monitor pops and compares on the falling edge.
module tb_prog_clock_divider;

  localparam int W   = 8;
  localparam int DEF = 2;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         clk_out;
  logic         tick;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  always #10 clk_in = ~clk_in;

  wire [3:0] outs = {clk_out, tick, div_ready, busy};

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got clk/tick/rdy/busy=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Period view: while running, position p runs 0..n-1; output is high for
  // the first ceil(n/2) positions and tick marks the last position.
  logic [3:0] exp_q[$];
  int         m_pend[$];
  bit         m_running;
  int         m_pos;
  int         m_n;

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      m_running = 1'b0;
      m_pos     = 0;
      m_n       = DEF;
      m_pend.delete();
      exp_q.delete();
    end else begin
      bit accept;
      int req;
      bit e_clk, e_tick;
      accept = div_valid && (m_pend.size() == 0);
      req    = int'(div_in);
      if (!m_running) begin
        if (m_pend.size() > 0) m_n = m_pend.pop_front();
        if (en) begin
          m_running = 1'b1;
          m_pos     = 0;
        end
      end else if (m_pos == m_n - 1) begin
        if (m_pend.size() > 0) m_n = m_pend.pop_front();
        m_pos = 0;
        if (!en) m_running = 1'b0;
      end else begin
        m_pos = m_pos + 1;
      end
      if (accept) m_pend.push_back((req < 2) ? 2 : req);
      e_clk  = m_running && (m_pos < (m_n + 1) / 2);
      e_tick = m_running && (m_pos == m_n - 1);
      exp_q.push_back({e_clk, e_tick, (m_pend.size() == 0), m_running});
    end
  end

  // ---------------- monitor ----------------
  int empty_cnt = 0;

  always @(negedge clk_in) begin
    if (!reset) begin
      empty_cnt = 0;
      chk("in_reset", outs, 4'b0010);
    end else if (exp_q.size() > 0) begin
      empty_cnt = 0;
      chk("cycle", outs, exp_q.pop_front());
    end else begin
      empty_cnt++;
      if (empty_cnt > 2) begin
        n_checks++;
        n_fail++;
        $display("FAIL model_stall: expectation queue empty for %0d cycles, required 0", empty_cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic load(input int d, input int hold);
    step();
    div_valid = 1'b1;
    div_in    = W'(d);
    step();
    div_valid = 1'b0;
    repeat (hold) step();
  endtask

  initial begin
    bit found;
    reset     = 1'b0;
    en        = 1'b1;
    div_valid = 1'b0;
    div_in    = '0;
    #5;
    chk("reset_hold", outs, 4'b0010);
    #30;
    reset = 1'b1;

    repeat (20) step();
    load(4, 30);
    load(5, 30);
    load(0, 20);
    load(1, 20);

    // Drop and re-raise en with N=4 to walk through DRAIN and IDLE.
    load(4, 10);
    en = 1'b0; step(); step();
    en = 1'b1; repeat (10) step();
    en = 1'b0; repeat (10) step();
    en = 1'b1; repeat (10) step();

    for (int i = 0; i < 3000; i++) begin
      step();
      en        = ($urandom_range(0, 9) != 0);
      div_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) div_in = W'($urandom_range(0, 60));
      else                            div_in = W'($urandom_range(0, 7));
    end

    // Reset in the middle of a high phase with an update pending.
    en = 1'b1;
    div_valid = 1'b0;
    load(9, 12);
    div_valid = 1'b1;
    div_in    = W'(3);
    step();
    div_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (clk_out === 1'b1) found = 1'b1;
    end
    chk("wait_high", {3'b000, found}, 4'b0001);
    #3;
    reset = 1'b0;
    #1;
    chk("reset_mid", outs, 4'b0010);
    #20;
    reset = 1'b1;

    for (int i = 0; i < 500; i++) begin
      step();
      en        = ($urandom_range(0, 7) != 0);
      div_valid = ($urandom_range(0, 4) == 0);
      div_in    = W'($urandom_range(0, 9));
    end
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
